// File: rtl/mem_scan_min.sv
// Read-only scan sequencer for the 256x8 data memory: walks Count bytes from
// BaseAddr and reports the minimum byte, its absolute address and the byte sum.
module mem_scan_min #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [ADDR_W-1:0] Count,
    output logic [ADDR_W-1:0] Address,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] MinValue,
    output logic [ADDR_W-1:0] MinIndex,
    output logic [SUM_W-1:0]  Sum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]   offset_q, offset_d;
    logic [DATA_W-1:0]   minValue_q, minValue_d;
    logic [ADDR_W-1:0]   minIndex_q, minIndex_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [ADDR_W-1:0]   scanAddr;

    // Address arithmetic is modulo 2^ADDR_W, so a scan past the top wraps to 0.
    assign scanAddr = base_q + offset_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            offset_q   <= '0;
            minValue_q <= '1;
            minIndex_q <= '0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            offset_q   <= offset_d;
            minValue_q <= minValue_d;
            minIndex_q <= minIndex_d;
            sum_q      <= sum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        offset_d   = offset_q;
        minValue_d = minValue_q;
        minIndex_d = minIndex_q;
        sum_d      = sum_q;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    base_d     = BaseAddr;
                    count_d    = Count;
                    offset_d   = '0;
                    minValue_d = '1;
                    minIndex_d = BaseAddr;
                    sum_d      = '0;
                    state_d    = (Count == '0) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                sum_d = sum_q + SUM_W'(ReadData);
                // Strict compare so that ties keep the earliest address.
                if (ReadData < minValue_q) begin
                    minValue_d = ReadData;
                    minIndex_d = scanAddr;
                end
                offset_d = offset_q + ADDR_W'(1);
                if (offset_q == count_q - ADDR_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Busy      = (state_q == S_SCAN);
    assign MemRead   = Busy;
    assign Address   = Busy ? scanAddr : '0;
    assign Done      = (state_q == S_DONE);
    assign MemWrite  = 1'b0;
    assign WriteData = '0;
    assign MinValue  = minValue_q;
    assign MinIndex  = minIndex_q;
    assign Sum       = sum_q;

endmodule

// File: tb/tb_mem_scan_min.sv
// Bench for mem_scan_min: a 256x8 combinational-read memory, a per-cycle
// reference model of the scan, and directed scenarios with literal results.
module tb_mem_scan_min;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic [7:0]  BaseAddr = 8'h00;
    logic [7:0]  Count = 8'h00;
    logic [7:0]  Address;
    logic        MemRead;
    logic        MemWrite;
    logic [7:0]  WriteData;
    logic [7:0]  ReadData;
    logic        Busy;
    logic        Done;
    logic [7:0]  MinValue;
    logic [7:0]  MinIndex;
    logic [15:0] Sum;

    int nChecks = 0;
    int nFails  = 0;

    logic [7:0] mem  [256];
    logic [7:0] snap [256];
    logic       loadEn = 1'b0;
    logic [7:0] loadAddr = 8'h00;
    logic [7:0] loadData = 8'h00;
    int         writeCount = 0;

    typedef struct packed {
        logic [7:0]  mn;
        logic [7:0]  ix;
        logic [15:0] sm;
    } result_t;

    int         mScanLeft = 0;
    int         mK = 0;
    logic       mDoneCycle = 1'b0;
    logic [7:0] mBase = 8'h00;
    result_t    mRes = '{mn: 8'hFF, ix: 8'h00, sm: 16'h0000};
    logic       expBusy;
    logic [7:0] expAddr;

    mem_scan_min dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .BaseAddr  (BaseAddr),
        .Count     (Count),
        .Address   (Address),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Busy      (Busy),
        .Done      (Done),
        .MinValue  (MinValue),
        .MinIndex  (MinIndex),
        .Sum       (Sum)
    );

    always #5 Clk = ~Clk;

    assign ReadData = mem[Address];

    always @(posedge Clk) begin
        if (loadEn) begin
            mem[loadAddr] <= loadData;
        end else if (MemWrite) begin
            mem[Address] <= WriteData;
            writeCount   <= writeCount + 1;
        end
    end

    function automatic result_t scanModel(input logic [7:0] base, input int cnt);
        result_t    r;
        logic [7:0] a;
        r = '{mn: 8'hFF, ix: base, sm: 16'h0000};
        for (int i = 0; i < cnt; i++) begin
            a    = base + 8'(i);
            r.sm = r.sm + 16'(mem[a]);
            if (mem[a] < r.mn) begin
                r.mn = mem[a];
                r.ix = a;
            end
        end
        return r;
    endfunction

    // Reference timeline: Count busy cycles after acceptance, then one Done cycle.
    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mScanLeft  <= 0;
            mK         <= 0;
            mDoneCycle <= 1'b0;
            mBase      <= 8'h00;
            mRes       <= '{mn: 8'hFF, ix: 8'h00, sm: 16'h0000};
        end else if (mDoneCycle) begin
            mDoneCycle <= 1'b0;
        end else if (mScanLeft > 0) begin
            mK        <= mK + 1;
            mScanLeft <= mScanLeft - 1;
            if (mScanLeft == 1) mDoneCycle <= 1'b1;
        end else if (Start) begin
            mBase      <= BaseAddr;
            mK         <= 0;
            mScanLeft  <= int'(Count);
            mDoneCycle <= (Count == 8'h00);
            mRes       <= scanModel(BaseAddr, int'(Count));
        end
    end

    assign expBusy = (mScanLeft > 0);
    assign expAddr = expBusy ? (mBase + 8'(mK)) : 8'h00;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge Clk) begin
        checkOutput("Busy", int'(Busy), int'(expBusy));
        checkOutput("MemRead", int'(MemRead), int'(expBusy));
        checkOutput("Address", int'(Address), int'(expAddr));
        checkOutput("Done", int'(Done), int'(mDoneCycle));
        checkOutput("MemWrite", int'(MemWrite), 0);
        checkOutput("WriteData", int'(WriteData), 0);
        if (!expBusy) begin
            checkOutput("MinValue", int'(MinValue), int'(mRes.mn));
            checkOutput("MinIndex", int'(MinIndex), int'(mRes.ix));
            checkOutput("Sum", int'(Sum), int'(mRes.sm));
        end
    end

    task automatic loadByte(input logic [7:0] a, input logic [7:0] d);
        @(negedge Clk);
        loadEn   = 1'b1;
        loadAddr = a;
        loadData = d;
        @(posedge Clk);
        #1 loadEn = 1'b0;
    endtask

    // Pulses Start, scrambles BaseAddr/Count once latched, optionally re-pulses
    // Start mid-scan, and measures cycles to Done and cycles spent Busy.
    task automatic applyStimulus(input logic [7:0] base, input logic [7:0] cnt,
                                 input int extraAt, output int lat, output int busyCycles);
        @(negedge Clk);
        Start      = 1'b1;
        BaseAddr   = base;
        Count      = cnt;
        lat        = 0;
        busyCycles = 0;
        for (int k = 1; k <= int'(cnt) + 8; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                Start    = 1'b0;
                BaseAddr = 8'hAA;
                Count    = 8'h07;
            end
            if (k == extraAt) begin
                Start    = 1'b1;
                BaseAddr = 8'hFE;
                Count    = 8'h02;
            end else if (k == extraAt + 1) begin
                Start = 1'b0;
            end
            if (Busy) busyCycles++;
            if (Done) begin
                lat = k;
                break;
            end
        end
        Start = 1'b0;
    endtask

    task automatic checkResults(input string tag, input logic [7:0] mn,
                                input logic [7:0] ix, input logic [15:0] sm);
        checkOutput({tag, ".MinValue"}, int'(MinValue), int'(mn));
        checkOutput({tag, ".MinIndex"}, int'(MinIndex), int'(ix));
        checkOutput({tag, ".Sum"}, int'(Sum), int'(sm));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int lat;
        int busyCycles;
        int doneSeen;
        int diffs;

        repeat (2) @(negedge Clk);
        checkResults("reset", 8'hFF, 8'h00, 16'h0000);
        checkOutput("reset.Busy", int'(Busy), 0);
        Rst = 1'b0;

        loadByte(8'h10, 8'h05);
        loadByte(8'h11, 8'h03);
        loadByte(8'h12, 8'h07);
        loadByte(8'h13, 8'h03);
        loadByte(8'hFE, 8'h20);
        loadByte(8'hFF, 8'h10);
        loadByte(8'h00, 8'h30);

        applyStimulus(8'h10, 8'd4, 0, lat, busyCycles);
        checkOutput("basic.latency", lat, 5);
        checkOutput("basic.busyCycles", busyCycles, 4);
        checkResults("basic", 8'h03, 8'h11, 16'h0012);
        repeat (3) @(negedge Clk);
        checkResults("basic.hold", 8'h03, 8'h11, 16'h0012);

        applyStimulus(8'hFE, 8'd3, 0, lat, busyCycles);
        checkOutput("wrap.latency", lat, 4);
        checkResults("wrap", 8'h10, 8'hFF, 16'h0060);

        applyStimulus(8'h40, 8'd0, 0, lat, busyCycles);
        checkOutput("zero.latency", lat, 1);
        checkOutput("zero.busyCycles", busyCycles, 0);
        checkResults("zero", 8'hFF, 8'h40, 16'h0000);

        applyStimulus(8'h10, 8'd4, 2, lat, busyCycles);
        checkOutput("restart.latency", lat, 5);
        checkResults("restart", 8'h03, 8'h11, 16'h0012);
        repeat (2) @(negedge Clk);

        @(negedge Clk);
        Start    = 1'b1;
        BaseAddr = 8'h10;
        Count    = 8'd4;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        checkOutput("abort.Busy", int'(Busy), 0);
        checkOutput("abort.MemRead", int'(MemRead), 0);
        checkOutput("abort.Address", int'(Address), 0);
        checkResults("abort", 8'hFF, 8'h00, 16'h0000);
        @(negedge Clk);
        Rst = 1'b0;
        doneSeen = 0;
        repeat (8) begin
            @(negedge Clk);
            if (Done) doneSeen++;
        end
        checkOutput("abort.noDone", doneSeen, 0);

        applyStimulus(8'h10, 8'd4, 0, lat, busyCycles);
        checkOutput("rerun.latency", lat, 5);
        checkResults("rerun", 8'h03, 8'h11, 16'h0012);

        for (int a = 0; a < 255; a++) loadByte(8'(a), 8'hFF);
        @(negedge Clk);
        for (int a = 0; a < 256; a++) snap[a] = mem[a];

        applyStimulus(8'h00, 8'd255, 0, lat, busyCycles);
        checkOutput("full.latency", lat, 256);
        checkOutput("full.busyCycles", busyCycles, 255);
        checkResults("full", 8'hFF, 8'h00, 16'hFE01);
        repeat (2) @(negedge Clk);

        diffs = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== snap[a]) diffs++;
        checkOutput("memUnchanged", diffs, 0);
        checkOutput("writeCount", writeCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
